pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the fixed per-stage field registers between pipeline stages.
- Carries an opaque DATA_W-bit payload. Callers pack stat/icode/Cnd/valE/valA/dstE/dstM or any other stage bundle into it.
- Adds a valid/ready handshake, stall (hold) and bubble (flush) control.
- Contains a 1-entry skid buffer, so in_ready_o is a pure register output and no combinational ready path crosses the stage.

Parameters:
DATA_W, 144, payload width in bits.
NOP_VAL, {DATA_W{1'b0}}, payload driven on out_data_o whenever out_valid_o=0; also the value loaded into cleared entries.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk_i  input  1  clock, rising edge.
rstn_i  input  1  asynchronous active-low reset.
in_valid_i  input  1  upstream payload valid.
in_data_i  input  DATA_W  upstream payload.
in_ready_o  output  1  stage can accept; registered.
out_valid_o  output  1  payload valid to downstream.
out_data_o  output  DATA_W  payload to downstream; NOP_VAL when not valid.
out_ready_i  input  1  downstream accepts.
stall_i  input  1  hold stage contents this cycle.
bubble_i  input  1  flush stage contents this cycle.

Behaviour:
- Reset (rstn_i=0, asynchronous): all of the following take effect immediately and without waiting for a clock edge.
  - Main and skid entries invalid; both data registers = NOP_VAL.
  - in_ready_o=1, out_valid_o=0, out_data_o=NOP_VAL.
  - Reset mid-transfer discards everything.
- Storage: main entry (m_v, m_d) drives the output; skid entry (s_v, s_d) holds overflow.
- Combinational outputs:
  - in_ready_o = ~s_v (registered state), further gated low by stall_i or bubble_i.
  - out_valid_o = m_v & ~stall_i & ~bubble_i.
  - out_data_o = m_d if m_v, else NOP_VAL.
- Transfers:
  - Input transfer: acc = in_valid_i & in_ready_o.
  - Output transfer: pop = out_valid_o & out_ready_i.
- Priority per cycle is bubble_i > stall_i > normal.
- bubble_i=1: next edge clears m_v and s_v and loads NOP_VAL into both data registers. No input is accepted that cycle. Upstream is expected to be flushing in the same cycle.
- stall_i=1 (bubble_i=0): all state held. acc=0 and pop=0.
- Normal operation, next-state rules:
  - m_v=0: acc loads main.
  - m_v=1 and pop, with s_v=1: skid moves to main and skid empties. acc is impossible because in_ready_o=0.
  - m_v=1 and pop, with s_v=0: acc loads main; otherwise main empties.
  - m_v=1, no pop, acc: payload goes to skid, s_v=1.
  - m_v=1, no pop, no acc: hold.
- Ordering: strict FIFO; the skid entry is never overtaken.
- Latency: 1 cycle from acc to out_valid_o when main was empty. Full throughput of 1 payload/cycle when out_ready_i stays high.
- Full boundary: m_v=s_v=1 gives in_ready_o=0 until the first pop. in_ready_o returns to 1 one edge after that pop.
- Empty boundary: pop never occurs with m_v=0.
- Simultaneous acc+pop with one entry held: the new payload replaces main and s_v stays 0.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt_o[CNT_W] and bubble_cnt_o[CNT_W].
  - Counters increment on each edge where stall_i=1 (and bubble_i=0), or bubble_i=1, respectively.
  - Counters saturate at all-ones and reset to 0 asynchronously.
  - perf_clr_i input 1 clears both synchronously; clear beats increment.
- Undefined: the ports, logic and perf_clr_i do not exist. Stage behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - NIBBLE/D_WORD widths.
  - ICODE_NOP, STAT_AOK, REG_NONE constants.
  - Per-stage bundle width constants (e.g. M_BUNDLE_W=144) and the NOP bundle constants used as NOP_VAL.
- One natural sub-module, pipe_sat_cnt (a saturating counter with clear). It is instantiated twice, only under PIPE_STAGE_PERF_EN.

Test Plan:
1. Reset, then in_valid_i=1 with data A=0x1, then 0x2, then 0x3, out_ready_i=1 throughout -> out_data_o = 0x1, 0x2, 0x3 on consecutive cycles, 1-cycle latency, in_ready_o stays 1.
2. out_ready_i=0; push 0x10 then 0x20 -> in_ready_o=0 after the second accept. Raise out_ready_i -> 0x10 then 0x20 in order; in_ready_o=1 one edge after the first pop.
3. Main and skid full, bubble_i=1 for 1 cycle -> next cycle out_valid_o=0, out_data_o=NOP_VAL, in_ready_o=1, and 0x10/0x20 are never emitted.
4. Main holds 0x5, stall_i=1 for 3 cycles with in_valid_i=1 and out_ready_i=1 -> out_valid_o=0 and in_ready_o=0 during the stall; 0x5 is emitted on the first cycle after the stall.
5. stall_i=1 and bubble_i=1 in the same cycle -> flush wins and the stage is empty next cycle. Assert rstn_i=0 mid-transfer -> outputs go to reset values immediately, with no clock edge needed.
6. With PIPE_STAGE_PERF_EN and CNT_W=4: 20 stall cycles -> stall_cnt_o=15 (saturated); perf_clr_i=1 -> 0 next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, encodings and per-stage NOP bundles.
//   NIBBLE/D_WORD    : field widths used in stage bundles
//   ICODE_NOP, STAT_AOK, REG_NONE : encodings that make up a harmless bundle
//   M_BUNDLE_W       : memory-stage bundle width {stat, icode, valE, valA, dstE, dstM}
//   M_BUNDLE_NOP     : bubble value for the memory stage, usable as NOP_VAL
package pipe_pkg;
    localparam int NIBBLE = 4;
    localparam int D_WORD = 64;
    localparam logic [NIBBLE-1:0] ICODE_NOP = 4'h1;
    localparam logic [NIBBLE-1:0] STAT_AOK = 4'h1;
    localparam logic [NIBBLE-1:0] REG_NONE = 4'hF;
    localparam int M_BUNDLE_W = 4 * NIBBLE + 2 * D_WORD;
    localparam logic [M_BUNDLE_W-1:0] M_BUNDLE_NOP =
        {STAT_AOK, ICODE_NOP, {D_WORD{1'b0}}, {D_WORD{1'b0}}, REG_NONE, REG_NONE};
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating event counter with synchronous clear.
//   clk_i, rstn_i : clock, asynchronous active-low reset (count -> 0)
//   clr_i         : synchronous clear, wins over inc_i
//   inc_i         : count one event this edge, sticks at all-ones
//   cnt_o [W]     : current count
module pipe_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i)
            cnt_o <= '0;
        else
            cnt_o <= clr_i ? '0 : (inc_i && !(&cnt_o)) ? cnt_o + 1'b1 : cnt_o;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready, stall, bubble and a 1-entry skid buffer.
//   clk_i, rstn_i            : clock, asynchronous active-low reset
//   in_valid_i/in_data_i     : upstream payload; in_ready_o depends only on state plus stall/bubble
//   out_valid_o/out_data_o   : downstream payload, NOP_VAL when main entry is empty
//   out_ready_i              : downstream accepts
//   stall_i / bubble_i       : hold / flush the stage (bubble wins)
//   With PIPE_STAGE_PERF_EN: perf_clr_i, stall_cnt_o[CNT_W], bubble_cnt_o[CNT_W] saturating counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = M_BUNDLE_W,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              stall_i,
    input  logic              bubble_i
`ifdef PIPE_STAGE_PERF_EN
    ,
    input  logic              perf_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);
    logic              m_v, s_v;
    logic [DATA_W-1:0] m_d, s_d;
    logic              go, acc, pop;

    assign go          = ~stall_i & ~bubble_i;
    assign in_ready_o  = ~s_v & go;
    assign out_valid_o = m_v & go;
    assign out_data_o  = m_v ? m_d : NOP_VAL;
    assign acc         = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // The skid is only ever occupied while main is, so when main is free or
    // draining, the skid (if any) has first claim on main, then the new input.
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_d <= NOP_VAL;
            s_d <= NOP_VAL;
        end else if (bubble_i) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_d <= NOP_VAL;
            s_d <= NOP_VAL;
        end else if (!stall_i) begin
            if (!m_v || pop) begin
                m_v <= s_v | acc;
                m_d <= s_v ? s_d : acc ? in_data_i : NOP_VAL;
                s_v <= 1'b0;
                s_d <= NOP_VAL;
            end else if (acc) begin
                s_v <= 1'b1;
                s_d <= in_data_i;
            end
        end

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (perf_clr_i),
        .inc_i  (stall_i & ~bubble_i),
        .cnt_o  (stall_cnt_o)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (perf_clr_i),
        .inc_i  (bubble_i),
        .cnt_o  (bubble_cnt_o)
    );
`endif
endmodule
